// File: rtl/keccak_padder_if.sv
// Message-word / block handshake bundle for keccak_padder.
// master: host + permutation-core side; slave: the padder itself.
interface keccak_padder_if #(
  parameter int RATE = 576
);
  logic [63:0]     in;
  logic            in_ready;
  logic            is_last;
  logic [2:0]      byte_num;
  logic            buffer_full;
  logic [RATE-1:0] out;
  logic            out_ready;
  logic            out_last;
  logic            f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, out_last
  );
endinterface

// File: rtl/keccak_padder.sv
// keccak_padder: packs 64-bit message words into RATE-bit blocks and applies
// Keccak multi-rate padding (domain byte, zero fill, final 0x80) on the last word.
// Optional macro KECCAK_PADDER_SHA3_DOMAIN_EN selects the SHA-3 domain byte 0x06
// instead of the original Keccak 0x01.
module keccak_padder #(
  parameter int RATE = 576
) (
  input logic             clk,
  input logic             reset,
  keccak_padder_if.slave  bus
);
  localparam int W  = RATE / 64;
  localparam int CW = $clog2(W + 1);

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
  localparam logic [7:0] DOMAIN = 8'h06;
`else
  localparam logic [7:0] DOMAIN = 8'h01;
`endif

  typedef enum logic [1:0] {ACCUM, FULL, DONE} state_t;

  state_t          state, state_n;
  logic [RATE-1:0] blk, blk_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last, last_n;
  logic [63:0]     keep_mask;
  logic [63:0]     pad_word;

  // Final word: keep the leading byte_num bytes, drop the domain byte right after them.
  always_comb begin
    keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {byte_num_shift(bus.byte_num)});
    pad_word  = (bus.in & keep_mask) | ({56'd0, DOMAIN} << {~bus.byte_num, 3'b000});
  end

  function automatic logic [5:0] byte_num_shift(input logic [2:0] n);
    return {n, 3'b000};
  endfunction

  // Next-state, slot writes and padding.
  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    blk_n   = blk;
    cnt_n   = cnt;
    last_n  = last;
    unique case (state)
      ACCUM: begin
        if (bus.in_ready) begin
          cnt_n = cnt + CW'(1);
          if (bus.is_last) begin
            for (int i = 0; i < W; i++) begin
              if (CW'(i) == cnt)     blk_n[RATE-1-64*i -: 64] = pad_word;
              else if (CW'(i) > cnt) blk_n[RATE-1-64*i -: 64] = '0;
            end
            blk_n[7:0] = blk_n[7:0] | 8'h80;
            last_n     = 1'b1;
            state_n    = FULL;
          end else begin
            for (int i = 0; i < W; i++) begin
              if (CW'(i) == cnt) blk_n[RATE-1-64*i -: 64] = bus.in;
            end
            if (cnt == CW'(W - 1)) state_n = FULL;
          end
        end
      end
      FULL: begin
        if (bus.f_ack) begin
          blk_n   = '0;
          cnt_n   = '0;
          last_n  = 1'b0;
          state_n = last ? DONE : ACCUM;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: the block register is reset too, because out must read zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= ACCUM;
      blk   <= '0;
      cnt   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      blk   <= blk_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  assign bus.buffer_full = (state != ACCUM);
  assign bus.out_ready   = (state == FULL);
  assign bus.out_last    = last;
  assign bus.out         = blk;
endmodule
